sram_bus_arbiter: RTL and testbench

Shares one SRAM-like slave port between the instruction-fetch and data-access SRAM-like master ports of the pipelined CPU core. Arbitrates per request with data priority and an anti-starvation override, and holds the grant stable until the slave accepts. Tracks up to `DEPTH` outstanding transactions in an in-order owner FIFO and routes each slave response back to its issuing master. Sits between the core's `inst_sram_*`/`data_sram_*` side and the single memory/bridge port.

---
 rtl/sram_bus_arbiter_if.sv | 23 ++
 rtl/sram_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like bus bundle: request/accept/response
// channel shared by the core masters and the slave port.
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master SRAM-like arbiter: data priority, inst
// anti-starvation, grant lock, in-order owner FIFO.
module sram_bus_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                resetn,
  sram_bus_arbiter_if.slave   inst,
  sram_bus_arbiter_if.slave   data,
  sram_bus_arbiter_if.master  s,
  output logic                protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [DEPTH-1:0] owner_q, owner_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             lock_owner_q, lock_owner_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             perr_q, perr_d;

  logic full;
  logic empty;
  logic starved;
  logic gnt_inst;
  logic gnt_data;
  logic gnt_req;
  logic push;
  logic pop;
  logic head;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign starved = inst.req && (starve_q == STARVE_MAX);

  // Grant: lock owner while locked, else data unless inst starved
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (locked_q) begin
      gnt_data = lock_owner_q;
      gnt_inst = !lock_owner_q;
    end else begin
      gnt_data = data.req && !starved;
      gnt_inst = inst.req && !gnt_data;
    end
  end

  assign gnt_req = (gnt_inst && inst.req)
                || (gnt_data && data.req);

  // s_req only looks at registered count: no data_ok->s_req path
  assign s.req = resetn && !full && gnt_req;
  assign push  = s.req && s.addr_ok;
  assign pop   = resetn && s.data_ok && !empty;
  assign head  = owner_q[rd_ptr_q];

  assign inst.addr_ok = push && gnt_inst;
  assign data.addr_ok = push && gnt_data;
  assign inst.data_ok = pop && !head;
  assign data.data_ok = pop && head;
  assign inst.rdata   = s.rdata;
  assign data.rdata   = s.rdata;

  assign protocol_err = perr_q;

  // Slave request fields follow the granted master, zero when idle
  always_comb begin
    s.wr    = 1'b0;
    s.size  = 2'd0;
    s.wstrb = 4'd0;
    s.addr  = 32'd0;
    s.wdata = 32'd0;
    unique case (1'b1)
      gnt_data: begin
        s.wr    = data.wr;
        s.size  = data.size;
        s.wstrb = data.wstrb;
        s.addr  = data.addr;
        s.wdata = data.wdata;
      end
      gnt_inst: begin
        s.wr    = inst.wr;
        s.size  = inst.size;
        s.wstrb = inst.wstrb;
        s.addr  = inst.addr;
        s.wdata = inst.wdata;
      end
      default: ;
    endcase
  end

  // Owner FIFO next state: push on accept, pop on response
  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      owner_d[wr_ptr_q] = gnt_data;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Lock, starvation and stray-response tracking
  always_comb begin
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
    starve_d     = starve_q;
    perr_d       = perr_q;
    if (push) begin
      locked_d = 1'b0;
    end else if (s.req) begin
      locked_d     = 1'b1;
      lock_owner_d = gnt_data;
    end
    if (inst.req && gnt_data) begin
      if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + SW'(1);
      end
    end else begin
      starve_d = '0;
    end
    if (s.data_ok && empty) begin
      perr_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
      starve_q     <= '0;
      perr_q       <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
      perr_q       <= perr_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios then
// random traffic against a queue-based reference model.
module tb_sram_bus_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM   = 3;

  logic clk = 1'b0;
  logic resetn;
  logic protocol_err;

  sram_bus_arbiter_if ib ();
  sram_bus_arbiter_if db ();
  sram_bus_arbiter_if sb ();

  sram_bus_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .inst(ib),
    .data(db),
    .s(sb),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  int total = 0;
  int bad   = 0;

  mreq_t       iv, dv;
  logic        rst_v;
  logic        s_aok, s_dok;
  logic [31:0] s_rd;

  bit oq[$];
  int starve;
  bit lk, lk_own, perr;

  logic        o_sreq, o_iaok, o_daok, o_idok, o_ddok;
  logic [31:0] o_saddr, o_rdata;

  int expd [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic mreq_t rnd_req();
    mreq_t r;
    r.req   = ($urandom_range(0, 9) < 6);
    r.wr    = 1'($urandom_range(0, 1));
    r.size  = 2'($urandom_range(0, 2));
    r.wstrb = 4'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic cyc();
    bit    full, gi, gd, esreq, push, pop, hd;
    mreq_t g;
    @(negedge clk);
    resetn     = rst_v;
    ib.req     = iv.req;
    ib.wr      = iv.wr;
    ib.size    = iv.size;
    ib.wstrb   = iv.wstrb;
    ib.addr    = iv.addr;
    ib.wdata   = iv.wdata;
    db.req     = dv.req;
    db.wr      = dv.wr;
    db.size    = dv.size;
    db.wstrb   = dv.wstrb;
    db.addr    = dv.addr;
    db.wdata   = dv.wdata;
    sb.addr_ok = s_aok;
    sb.data_ok = s_dok;
    sb.rdata   = s_rd;
    #1;
    full = (oq.size() >= DEPTH);
    if (lk) begin
      gd = lk_own;
      gi = !lk_own;
    end else begin
      gd = dv.req && !(iv.req && starve == LIM);
      gi = iv.req && !gd;
    end
    esreq = rst_v && !full
         && ((gi && iv.req) || (gd && dv.req));
    push = esreq && s_aok;
    pop  = rst_v && s_dok && (oq.size() > 0);
    hd   = (oq.size() > 0) ? oq[0] : 1'b0;
    if (gd) g = dv;
    else if (gi) g = iv;
    else g = '0;
    o_sreq  = sb.req;
    o_saddr = sb.addr;
    o_iaok  = ib.addr_ok;
    o_daok  = db.addr_ok;
    o_idok  = ib.data_ok;
    o_ddok  = db.data_ok;
    o_rdata = ib.rdata;
    chk("s_req", sb.req, esreq);
    if (esreq || !(gi || gd)) begin
      chk("s_addr", sb.addr, g.addr);
      chk("s_wdata", sb.wdata, g.wdata);
      chk("s_ctl", {sb.wr, sb.size, sb.wstrb},
          {g.wr, g.size, g.wstrb});
    end
    chk("i_aok", ib.addr_ok, push && gi);
    chk("d_aok", db.addr_ok, push && gd);
    chk("i_dok", ib.data_ok, pop && !hd);
    chk("d_dok", db.data_ok, pop && hd);
    chk("i_rdata", ib.rdata, s_rd);
    chk("d_rdata", db.rdata, s_rd);
    chk("perr", protocol_err, perr);
    if (!rst_v) begin
      oq.delete();
      starve = 0;
      lk     = 0;
      lk_own = 0;
      perr   = 0;
    end else begin
      if (s_dok && oq.size() == 0) perr = 1;
      if (push) oq.push_back(gd);
      if (pop) void'(oq.pop_front());
      if (push) lk = 0;
      else if (esreq) begin
        lk     = 1;
        lk_own = gd;
      end
      if (iv.req && gd)
        starve = (starve < LIM) ? starve + 1 : LIM;
      else
        starve = 0;
    end
  endtask

  task automatic idle();
    iv    = '0;
    dv    = '0;
    s_aok = 1'b0;
    s_dok = 1'b0;
    s_rd  = 32'h0;
  endtask

  initial begin
    starve = 0;
    lk     = 0;
    lk_own = 0;
    perr   = 0;
    idle();
    rst_v = 1'b0;
    cyc();
    cyc();
    rst_v = 1'b1;
    cyc();
    chk("rst_sreq", o_sreq, 0);
    chk("rst_perr", protocol_err, 0);

    iv = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000000, 32'h0};
    s_aok = 1'b1;
    cyc();
    chk("rd_aok", o_iaok, 1);
    iv.req = 1'b0;
    s_aok  = 1'b0;
    cyc();
    s_dok = 1'b1;
    s_rd  = 32'h12345678;
    cyc();
    chk("rd_dok", o_idok, 1);
    chk("rd_data", o_rdata, 32'h12345678);
    chk("rd_ddok", o_ddok, 0);
    s_dok = 1'b0;

    iv = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1000, 32'h0};
    dv = '{1'b1, 1'b1, 2'd2, 4'hf, 32'h2000, 32'hab};
    s_aok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_dok = (k > 0);
      cyc();
      chk("cont_d", o_daok, expd[k]);
      chk("cont_i", o_iaok, !expd[k]);
      if (k > 0) chk("cont_ord", o_ddok, expd[k-1]);
    end
    iv.req = 1'b0;
    dv.req = 1'b0;
    s_aok  = 1'b0;
    s_dok  = 1'b1;
    cyc();
    s_dok = 1'b0;

    dv = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h3000, 32'h0};
    for (int k = 0; k < 4; k++) begin
      iv.req = (k >= 1);
      s_aok  = (k == 3);
      cyc();
      chk("lk_addr", o_saddr, 32'h3000);
      chk("lk_daok", o_daok, (k == 3));
    end
    dv.req = 1'b0;
    s_aok  = 1'b1;
    cyc();
    chk("lk_iaok", o_iaok, 1);
    iv.req = 1'b0;
    s_aok  = 1'b0;
    s_dok  = 1'b1;
    cyc();
    cyc();
    s_dok = 1'b0;

    dv.req = 1'b1;
    s_aok  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dv.addr = 32'h4000 + 32'(k * 4);
      cyc();
      chk("fill", o_daok, 1);
    end
    cyc();
    chk("full_sreq", o_sreq, 0);
    s_dok = 1'b1;
    cyc();
    chk("full_same", o_sreq, 0);
    chk("full_pop", o_ddok, 1);
    s_dok = 1'b0;
    cyc();
    chk("full_reen", o_sreq, 1);
    s_dok = 1'b1;
    cyc();
    chk("full_blk", o_sreq, 0);
    cyc();
    chk("pp_sreq", o_sreq, 1);
    chk("pp_dok", o_ddok, 1);
    s_dok = 1'b0;
    cyc();
    chk("pp_push", o_sreq, 1);
    cyc();
    chk("pp_full", o_sreq, 0);
    for (int k = 0; k < 10; k++) begin
      dv.addr = 32'h5000 + 32'(k * 4);
      s_dok = 1'b1;
      s_rd  = $urandom;
      cyc();
    end
    dv.req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_dok = (oq.size() > 0);
      cyc();
    end

    idle();
    s_dok = 1'b1;
    cyc();
    chk("stray_dok", o_idok | o_ddok, 0);
    s_dok = 1'b0;
    cyc();
    chk("stray_perr", protocol_err, 1);
    iv = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h6000, 32'h0};
    s_aok = 1'b1;
    cyc();
    cyc();
    iv.req = 1'b0;
    s_aok  = 1'b0;
    rst_v  = 1'b0;
    cyc();
    rst_v = 1'b1;
    cyc();
    chk("rst2_perr", protocol_err, 0);
    s_dok = 1'b1;
    cyc();
    chk("rst2_nodok", o_idok | o_ddok, 0);
    s_dok = 1'b0;
    cyc();

    iv = rnd_req();
    dv = rnd_req();
    for (int n = 0; n < 3000; n++) begin
      rst_v = ($urandom_range(0, 199) != 0);
      s_aok = ($urandom_range(0, 9) < 6);
      if (oq.size() > 0) s_dok = ($urandom_range(0, 9) < 5);
      else s_dok = ($urandom_range(0, 29) == 0);
      s_rd = $urandom;
      cyc();
      if (!iv.req || o_iaok) iv = rnd_req();
      if (!dv.req || o_daok) dv = rnd_req();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
